// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the 19-bit core: widths, bubble encoding
// and opcode field layout used by fetch and decode.
package fetch_unit_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 19;

    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 19'd0;
    localparam logic [PC_W-1:0]    PC_ZERO      = 12'd0;
    localparam logic [PC_W-1:0]    PC_ONE       = 12'd1;

    // Opcode fields: full 5-bit opcode and the 3-bit major class
    localparam int OPCODE_HI  = 18;
    localparam int OPCODE_LO  = 14;
    localparam int OPCLASS_LO = 16;

    localparam logic [2:0] OP_JUMP   = 3'b111;
    localparam logic [2:0] OP_BRANCH = 3'b101;

    function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_HI:OPCODE_LO];
    endfunction

    function automatic logic is_ctrl_transfer(input logic [INSTR_W-1:0] instr);
        logic [2:0] cls;
        cls = instr[OPCODE_HI:OPCLASS_LO];
        return (cls == OP_JUMP) || (cls == OP_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready handshake between fetch and memory.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic               req;
    logic [PC_W-1:0]    addr;
    logic               ready;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry instruction+PC skid buffer that catches a fetched word while
// decode cannot accept it.
module fetch_hold_buf
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    logic               full_r;
    logic [INSTR_W-1:0] instr_r;
    logic [PC_W-1:0]    pc_r;

    // Buffer storage; a load never coincides with a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r  <= 1'b0;
            instr_r <= BUBBLE_INSTR;
            pc_r    <= PC_ZERO;
        end else if (load) begin
            full_r  <= 1'b1;
            instr_r <= load_instr;
            pc_r    <= load_pc;
        end else if (clear) begin
            full_r  <= 1'b0;
            instr_r <= BUBBLE_INSTR;
            pc_r    <= PC_ZERO;
        end else begin
            full_r  <= full_r;
            instr_r <= instr_r;
            pc_r    <= pc_r;
        end
    end

    assign full  = full_r;
    assign instr = instr_r;
    assign pc    = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID pipeline register: owns the PC, runs the
// memory handshake, buffers a word under decode stall and applies redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'd0
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_writebar,
    input  logic                IF_ID_loadbar,
    input  logic                IF_ID_flush,
    input  logic                redirect_en,
    input  logic [PC_W-1:0]     redirect_pc,
    fetch_unit_if.master        imem,
    output logic [INSTR_W-1:0]  IF_ID_instruction,
    output logic [PC_W-1:0]     IF_ID_pc,
    output logic                IF_ID_valid,
    output logic [PC_W-1:0]     pc
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]         state_r, state_nx_s;
    logic [PC_W-1:0]    pc_r, pc_nx_s;
    logic [PC_W-1:0]    stale_addr_r, stale_addr_nx_s;
    logic [INSTR_W-1:0] ifid_instr_r, ifid_instr_nx_s;
    logic [PC_W-1:0]    ifid_pc_r, ifid_pc_nx_s;
    logic               ifid_valid_r, ifid_valid_nx_s;

    logic               xfer_s, take_s, word_ok_s;
    logic               buf_load_s, buf_clear_s, buf_full_s;
    logic [INSTR_W-1:0] buf_instr_s;
    logic [PC_W-1:0]    buf_pc_s;

    // Request side depends on registered state only, never on ready
    assign imem.req  = (state_r == ST_FETCH) || (state_r == ST_DISCARD);
    assign imem.addr = (state_r == ST_DISCARD) ? stale_addr_r : pc_r;

    assign xfer_s = imem.req & imem.ready;
    assign take_s = ~IF_ID_loadbar & ~IF_ID_flush;

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load_s),
        .clear      (buf_clear_s),
        .load_instr (imem.rdata),
        .load_pc    (pc_r),
        .full       (buf_full_s),
        .instr      (buf_instr_s),
        .pc         (buf_pc_s)
    );

    // Fetch FSM: next state, next PC, hold-buffer control
    always_comb begin
        state_nx_s      = state_r;
        pc_nx_s         = pc_r;
        stale_addr_nx_s = stale_addr_r;
        buf_load_s      = 1'b0;
        buf_clear_s     = 1'b0;
        word_ok_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (redirect_en) begin
                    pc_nx_s    = redirect_pc;
                    state_nx_s = ST_FETCH;
                end else if (!pc_writebar) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (redirect_en) begin
                    pc_nx_s = redirect_pc;
                    if (xfer_s) begin
                        state_nx_s = ST_FETCH;
                    end else begin
                        // Request cannot be withdrawn: finish it at the old address
                        stale_addr_nx_s = pc_r;
                        state_nx_s      = ST_DISCARD;
                    end
                end else if (xfer_s) begin
                    pc_nx_s = pc_r + PC_ONE;
                    if (take_s) begin
                        word_ok_s  = 1'b1;
                        state_nx_s = pc_writebar ? ST_IDLE : ST_FETCH;
                    end else begin
                        buf_load_s = 1'b1;
                        state_nx_s = ST_HOLD;
                    end
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_en) begin
                    buf_clear_s = 1'b1;
                    pc_nx_s     = redirect_pc;
                    state_nx_s  = ST_FETCH;
                end else if (take_s) begin
                    buf_clear_s = 1'b1;
                    state_nx_s  = pc_writebar ? ST_IDLE : ST_FETCH;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                if (redirect_en) begin
                    pc_nx_s = redirect_pc;
                end else begin
                    pc_nx_s = pc_r;
                end
                if (xfer_s) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_DISCARD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // IF/ID input select: flush, hold, buffered word, fresh word, bubble
    always_comb begin
        ifid_instr_nx_s = ifid_instr_r;
        ifid_pc_nx_s    = ifid_pc_r;
        ifid_valid_nx_s = ifid_valid_r;
        if (IF_ID_flush) begin
            ifid_instr_nx_s = BUBBLE_INSTR;
            ifid_pc_nx_s    = PC_ZERO;
            ifid_valid_nx_s = 1'b0;
        end else if (IF_ID_loadbar) begin
            ifid_instr_nx_s = ifid_instr_r;
            ifid_pc_nx_s    = ifid_pc_r;
            ifid_valid_nx_s = ifid_valid_r;
        end else if (buf_full_s && !redirect_en) begin
            ifid_instr_nx_s = buf_instr_s;
            ifid_pc_nx_s    = buf_pc_s;
            ifid_valid_nx_s = 1'b1;
        end else if (word_ok_s) begin
            ifid_instr_nx_s = imem.rdata;
            ifid_pc_nx_s    = pc_r;
            ifid_valid_nx_s = 1'b1;
        end else begin
            ifid_instr_nx_s = BUBBLE_INSTR;
            ifid_pc_nx_s    = PC_ZERO;
            ifid_valid_nx_s = 1'b0;
        end
    end

    // State, PC and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            stale_addr_r <= PC_ZERO;
            ifid_instr_r <= BUBBLE_INSTR;
            ifid_pc_r    <= PC_ZERO;
            ifid_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            pc_r         <= pc_nx_s;
            stale_addr_r <= stale_addr_nx_s;
            ifid_instr_r <= ifid_instr_nx_s;
            ifid_pc_r    <= ifid_pc_nx_s;
            ifid_valid_r <= ifid_valid_nx_s;
        end
    end

    assign IF_ID_instruction = ifid_instr_r;
    assign IF_ID_pc          = ifid_pc_r;
    assign IF_ID_valid       = ifid_valid_r;
    assign pc                = pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pc_writebar = 1'b1;
    logic               IF_ID_loadbar = 1'b0;
    logic               IF_ID_flush = 1'b0;
    logic               redirect_en = 1'b0;
    logic [PC_W-1:0]    redirect_pc = 12'd0;
    logic [INSTR_W-1:0] IF_ID_instruction;
    logic [PC_W-1:0]    IF_ID_pc;
    logic               IF_ID_valid;
    logic [PC_W-1:0]    pc;
    logic               ready = 1'b1;
    logic [INSTR_W-1:0] key = 19'd0;

    int vectors = 0;
    int miscompares = 0;

    fetch_unit_if imem();

    // Memory returns its own address (optionally scrambled by key)
    assign imem.ready = ready;
    assign imem.rdata = {{(INSTR_W-PC_W){1'b0}}, imem.addr} ^ key;

    fetch_unit #(.RESET_PC(12'd0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_writebar       (pc_writebar),
        .IF_ID_loadbar     (IF_ID_loadbar),
        .IF_ID_flush       (IF_ID_flush),
        .redirect_en       (redirect_en),
        .redirect_pc       (redirect_pc),
        .imem              (imem),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_pc          (IF_ID_pc),
        .IF_ID_valid       (IF_ID_valid),
        .pc                (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc_writebar = 1'b0; IF_ID_loadbar = 1'b0; IF_ID_flush = 1'b0;
        redirect_en = 1'b0; redirect_pc = 12'd0; ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic advance_to(input logic [PC_W-1:0] a);
        int k;
        k = 0;
        while (!(imem.req === 1'b1 && imem.addr === a) && k < 200) begin
            tick();
            k++;
        end
        vectors++;
        if (k >= 200) begin
            miscompares++;
            $display("FAIL advance_to: addr %0h never requested (last %0h), want %0h", imem.addr, imem.addr, a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key = 19'd0; ready = 1'b1;
        pc_writebar = 1'b0; IF_ID_loadbar = 1'b0; IF_ID_flush = 1'b0; redirect_en = 1'b0;
        tick();
        vectors++;
        if (imem.req !== 1'b0 || pc !== 12'd0 || IF_ID_valid !== 1'b0 ||
            IF_ID_instruction !== 19'd0 || IF_ID_pc !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_state: got req=%b pc=%0h v=%b i=%0h ipc=%0h, want all 0",
                     imem.req, pc, IF_ID_valid, IF_ID_instruction, IF_ID_pc);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (imem.req !== 1'b1 || imem.addr !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_first_req: got req=%b addr=%0h, want req=1 addr=0", imem.req, imem.addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (IF_ID_valid !== 1'b1 || IF_ID_instruction !== INSTR_W'(i) || IF_ID_pc !== PC_W'(i)) begin
                miscompares++;
                $display("FAIL zero_wait_%0d: got v=%b i=%0h pc=%0h, want v=1 i=%0h pc=%0h",
                         i, IF_ID_valid, IF_ID_instruction, IF_ID_pc, i, i);
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        advance_to(12'd5);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (imem.req !== 1'b1 || imem.addr !== 12'd5 || IF_ID_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_%0d: got req=%b addr=%0h v=%b, want req=1 addr=5 v=0",
                         i, imem.req, imem.addr, IF_ID_valid);
            end
        end
        ready = 1'b1;
        tick();
        vectors++;
        if (IF_ID_valid !== 1'b1 || IF_ID_instruction !== 19'd5 || IF_ID_pc !== 12'd5) begin
            miscompares++;
            $display("FAIL wait_done: got v=%b i=%0h pc=%0h, want v=1 i=5 pc=5",
                     IF_ID_valid, IF_ID_instruction, IF_ID_pc);
        end
    endtask

    task automatic test_hold_buffer();
        do_reset();
        advance_to(12'd7);
        IF_ID_loadbar = 1'b1; pc_writebar = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (imem.req !== 1'b0 || IF_ID_valid !== 1'b1 || IF_ID_pc !== 12'd6 || pc !== 12'd8) begin
                miscompares++;
                $display("FAIL hold_%0d: got req=%b v=%b ipc=%0h pc=%0h, want req=0 v=1 ipc=6 pc=8",
                         i, imem.req, IF_ID_valid, IF_ID_pc, pc);
            end
        end
        IF_ID_loadbar = 1'b0; pc_writebar = 1'b0;
        tick();
        vectors++;
        if (IF_ID_valid !== 1'b1 || IF_ID_instruction !== 19'd7 || imem.req !== 1'b1 || imem.addr !== 12'd8) begin
            miscompares++;
            $display("FAIL hold_release: got v=%b i=%0h req=%b addr=%0h, want v=1 i=7 req=1 addr=8",
                     IF_ID_valid, IF_ID_instruction, imem.req, imem.addr);
        end
        tick();
        vectors++;
        if (IF_ID_instruction !== 19'd8 || IF_ID_pc !== 12'd8) begin
            miscompares++;
            $display("FAIL hold_next: got i=%0h pc=%0h, want i=8 pc=8", IF_ID_instruction, IF_ID_pc);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        advance_to(12'd9);
        ready = 1'b0;
        tick();
        redirect_en = 1'b1; redirect_pc = 12'h040;
        tick();
        redirect_en = 1'b0;
        vectors++;
        if (imem.req !== 1'b1 || imem.addr !== 12'd9 || pc !== 12'h040 || IF_ID_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_stale: got req=%b addr=%0h pc=%0h v=%b, want req=1 addr=9 pc=40 v=0",
                     imem.req, imem.addr, pc, IF_ID_valid);
        end
        tick();
        vectors++;
        if (imem.addr !== 12'd9) begin
            miscompares++;
            $display("FAIL redir_stale_hold: got addr=%0h, want 9", imem.addr);
        end
        ready = 1'b1;
        tick();
        vectors++;
        if (imem.addr !== 12'h040 || imem.req !== 1'b1 || IF_ID_valid !== 1'b0 || IF_ID_pc !== 12'd0) begin
            miscompares++;
            $display("FAIL redir_drop: got addr=%0h req=%b v=%b ipc=%0h, want addr=40 req=1 v=0 ipc=0",
                     imem.addr, imem.req, IF_ID_valid, IF_ID_pc);
        end
        tick();
        vectors++;
        if (IF_ID_valid !== 1'b1 || IF_ID_instruction !== 19'h040 || IF_ID_pc !== 12'h040) begin
            miscompares++;
            $display("FAIL redir_target: got v=%b i=%0h pc=%0h, want v=1 i=40 pc=40",
                     IF_ID_valid, IF_ID_instruction, IF_ID_pc);
        end
    endtask

    task automatic test_redirect_zero_wait();
        do_reset();
        advance_to(12'd6);
        redirect_en = 1'b1; redirect_pc = 12'h020;
        tick();
        redirect_en = 1'b0;
        vectors++;
        if (imem.req !== 1'b1 || imem.addr !== 12'h020 || IF_ID_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir0_req: got req=%b addr=%0h v=%b, want req=1 addr=20 v=0",
                     imem.req, imem.addr, IF_ID_valid);
        end
        tick();
        vectors++;
        if (IF_ID_valid !== 1'b1 || IF_ID_instruction !== 19'h020) begin
            miscompares++;
            $display("FAIL redir0_target: got v=%b i=%0h, want v=1 i=20", IF_ID_valid, IF_ID_instruction);
        end
    endtask

    task automatic test_flush_buffer();
        do_reset();
        advance_to(12'd4);
        IF_ID_flush = 1'b1;
        tick();
        IF_ID_flush = 1'b0;
        vectors++;
        if (IF_ID_valid !== 1'b0 || IF_ID_instruction !== 19'd0 || imem.req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_buf: got v=%b i=%0h req=%b, want v=0 i=0 req=0",
                     IF_ID_valid, IF_ID_instruction, imem.req);
        end
        tick();
        vectors++;
        if (IF_ID_valid !== 1'b1 || IF_ID_instruction !== 19'd4 || imem.addr !== 12'd5 || imem.req !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_release: got v=%b i=%0h req=%b addr=%0h, want v=1 i=4 req=1 addr=5",
                     IF_ID_valid, IF_ID_instruction, imem.req, imem.addr);
        end
    endtask

    task automatic test_all_in_hold();
        do_reset();
        advance_to(12'd12);
        IF_ID_loadbar = 1'b1; pc_writebar = 1'b1;
        tick();
        redirect_en = 1'b1; redirect_pc = 12'h080; IF_ID_flush = 1'b1;
        tick();
        redirect_en = 1'b0; IF_ID_flush = 1'b0; IF_ID_loadbar = 1'b0; pc_writebar = 1'b0;
        vectors++;
        if (IF_ID_valid !== 1'b0 || IF_ID_instruction !== 19'd0 || IF_ID_pc !== 12'd0 ||
            imem.req !== 1'b1 || imem.addr !== 12'h080) begin
            miscompares++;
            $display("FAIL all_hold: got v=%b i=%0h ipc=%0h req=%b addr=%0h, want v=0 i=0 ipc=0 req=1 addr=80",
                     IF_ID_valid, IF_ID_instruction, IF_ID_pc, imem.req, imem.addr);
        end
        tick();
        vectors++;
        if (IF_ID_valid !== 1'b1 || IF_ID_instruction !== 19'h080) begin
            miscompares++;
            $display("FAIL all_hold_target: got v=%b i=%0h, want v=1 i=80", IF_ID_valid, IF_ID_instruction);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        advance_to(12'd3);
        ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (imem.req !== 1'b0 || pc !== 12'd0 || IF_ID_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got req=%b pc=%0h v=%b, want req=0 pc=0 v=0", imem.req, pc, IF_ID_valid);
        end
        tick();
        rst_n = 1'b1; ready = 1'b1;
        tick();
        vectors++;
        if (imem.req !== 1'b1 || imem.addr !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_mid_restart: got req=%b addr=%0h, want req=1 addr=0", imem.req, imem.addr);
        end
        tick();
        vectors++;
        if (IF_ID_valid !== 1'b1 || IF_ID_instruction !== 19'd0 || IF_ID_pc !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_mid_first: got v=%b i=%0h pc=%0h, want v=1 i=0 pc=0",
                     IF_ID_valid, IF_ID_instruction, IF_ID_pc);
        end
    endtask

    // Random stalls/flushes/wait states: fetches must be sequential, words must
    // reach IF/ID in fetch order, holds and flushes must behave as stated
    task automatic test_random();
        logic               p_req, p_ready, p_flush, p_loadbar, p_v;
        logic [PC_W-1:0]    p_addr, p_ipc, exp_fetch;
        logic [INSTR_W-1:0] p_i, exp_i;
        logic [PC_W-1:0]    q[$];
        int                 shown;
        key = 19'h5A5A5;
        do_reset();
        exp_fetch = 12'd0;
        shown = 0;
        for (int c = 0; c < 3000; c++) begin
            ready         = ($urandom_range(0, 9) < 7);
            IF_ID_loadbar = ($urandom_range(0, 4) == 0);
            pc_writebar   = ($urandom_range(0, 4) == 0);
            IF_ID_flush   = ($urandom_range(0, 9) == 0);
            p_req = imem.req; p_addr = imem.addr; p_ready = ready;
            p_flush = IF_ID_flush; p_loadbar = IF_ID_loadbar;
            p_v = IF_ID_valid; p_i = IF_ID_instruction; p_ipc = IF_ID_pc;
            tick();
            if (p_req && !p_ready) begin
                vectors++;
                if (imem.req !== 1'b1 || imem.addr !== p_addr) begin
                    miscompares++;
                    $display("FAIL rnd_stable c=%0d: got req=%b addr=%0h, want req=1 addr=%0h", c, imem.req, imem.addr, p_addr);
                end
            end
            if (p_req && p_ready) begin
                vectors++;
                if (p_addr !== exp_fetch) begin
                    miscompares++;
                    $display("FAIL rnd_fetch_order c=%0d: got addr=%0h, want %0h", c, p_addr, exp_fetch);
                end
                q.push_back(p_addr);
                exp_fetch = exp_fetch + 12'd1;
            end
            vectors++;
            if (pc !== exp_fetch) begin
                miscompares++;
                $display("FAIL rnd_pc c=%0d: got %0h, want %0h", c, pc, exp_fetch);
            end
            if (p_flush) begin
                vectors++;
                if (IF_ID_valid !== 1'b0 || IF_ID_instruction !== 19'd0 || IF_ID_pc !== 12'd0) begin
                    miscompares++;
                    $display("FAIL rnd_flush c=%0d: got v=%b i=%0h pc=%0h, want bubble", c, IF_ID_valid, IF_ID_instruction, IF_ID_pc);
                end
            end else if (p_loadbar) begin
                vectors++;
                if (IF_ID_valid !== p_v || IF_ID_instruction !== p_i || IF_ID_pc !== p_ipc) begin
                    miscompares++;
                    $display("FAIL rnd_hold c=%0d: got v=%b i=%0h pc=%0h, want v=%b i=%0h pc=%0h",
                             c, IF_ID_valid, IF_ID_instruction, IF_ID_pc, p_v, p_i, p_ipc);
                end
            end else if (IF_ID_valid === 1'b1) begin
                exp_i = {{(INSTR_W-PC_W){1'b0}}, IF_ID_pc} ^ key;
                vectors++;
                if (q.size() == 0 || IF_ID_pc !== q[0] || IF_ID_instruction !== exp_i) begin
                    miscompares++;
                    $display("FAIL rnd_stream c=%0d: got i=%0h pc=%0h, want i=%0h pc=%0h (pending %0d)",
                             c, IF_ID_instruction, IF_ID_pc, exp_i, (q.size() == 0) ? 12'd0 : q[0], q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
                shown++;
            end else begin
                vectors++;
                if (IF_ID_instruction !== 19'd0 || IF_ID_pc !== 12'd0) begin
                    miscompares++;
                    $display("FAIL rnd_bubble c=%0d: got i=%0h pc=%0h, want 0 0", c, IF_ID_instruction, IF_ID_pc);
                end
            end
        end
        vectors++;
        if (shown < 500) begin
            miscompares++;
            $display("FAIL rnd_progress: got %0d instructions, want at least 500", shown);
        end
        IF_ID_loadbar = 1'b0; IF_ID_flush = 1'b0; pc_writebar = 1'b0; ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_hold_buffer();
        test_redirect_wait();
        test_redirect_zero_wait();
        test_flush_buffer();
        test_all_in_hold();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
